// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and constants for the memory-access controller: access unit
// encoding, response fault codes, controller states and the default
// locations of the memory-mapped timer words.
package mem_ctrl_pkg;

   // Access size as presented by the datapath; 2'b11 is illegal and has no
   // enumerator on purpose so it falls into the default decode.
   typedef enum logic [1:0] {
      UNIT_BYTE = 2'b00,
      UNIT_HALF = 2'b01,
      UNIT_WORD = 2'b10
   } mem_unit_t;

   typedef enum logic [1:0] {
      FAULT_NONE       = 2'b00,
      FAULT_MISALIGNED = 2'b01,
      FAULT_TIMEOUT    = 2'b10
   } mem_fault_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RAM_WAIT = 2'b01,
      RESP     = 2'b10
   } mem_ctrl_state_t;

   // Timer window: low words; the high words sit at +4.
   localparam logic [31:0] DEFAULT_MTIMECMP_ADDR = 32'h0200_4000;
   localparam logic [31:0] DEFAULT_MTIME_ADDR    = 32'h0200_BFF8;

   // RAM_WAIT cycles allowed before the access is abandoned.
   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
// Bundles the datapath request/response handshake and the word-wide RAM
// port of the memory controller.
//   req_*  : datapath -> controller request (valid/ready handshake)
//   rsp_*  : controller -> datapath one-cycle response strobe and data
//   ram_*  : controller <-> RAM, request held until ram_ack
// modport slave  : the controller side
// modport master : the datapath/RAM side (used by the environment)
interface mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_unit;
   logic [31:0] req_addr;
   logic [31:0] req_wd;

   logic        rsp_valid;
   logic [31:0] rsp_rd;
   logic [1:0]  rsp_fault;

   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wd;
   logic        ram_ack;
   logic [31:0] ram_rd;

   modport slave (
      input  req_valid, req_we, req_unit, req_addr, req_wd,
      output req_ready,
      output rsp_valid, rsp_rd, rsp_fault,
      output ram_req, ram_we, ram_addr, ram_be, ram_wd,
      input  ram_ack, ram_rd
   );

   modport master (
      output req_valid, req_we, req_unit, req_addr, req_wd,
      input  req_ready,
      input  rsp_valid, rsp_rd, rsp_fault,
      input  ram_req, ram_we, ram_addr, ram_be, ram_wd,
      output ram_ack, ram_rd
   );
endinterface

// File: rtl/mem_store_aligner.sv
// mem_store_aligner
// Pure combinational lane logic for one access.
//   unit       in  2   access size (byte/half/word, 11 illegal)
//   addr_lo    in  2   byte offset within the word
//   wd         in  32  right-aligned store data
//   be         out 4   byte enables for a store of this size/offset
//   wd_lanes   out 32  store data replicated across every lane it may hit
//   misaligned out 1   access crosses its natural alignment or unit illegal
module mem_store_aligner
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  unit,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   output logic [3:0]  be,
   output logic [31:0] wd_lanes,
   output logic        misaligned
);

   // Replicating the data lets the RAM pick whichever lane the byte
   // enables select, so no data shifter is needed on the store path.
   always_comb begin
      be         = 4'b0000;
      wd_lanes   = wd;
      misaligned = 1'b0;
      case (mem_unit_t'(unit))
         UNIT_BYTE: begin
            be       = 4'b0001 << addr_lo;
            wd_lanes = {4{wd[7:0]}};
         end
         UNIT_HALF: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wd_lanes   = {2{wd[15:0]}};
            misaligned = addr_lo[0];
         end
         UNIT_WORD: begin
            be         = 4'b1111;
            misaligned = |addr_lo;
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Memory-access controller between the core datapath and a word-wide RAM,
// with a decoded timer window exposing mtime (the mcycle counter) and
// mtimecmp.
//   clk             in   system clock
//   reset           in   asynchronous, active-high
//   bus             slave modport of mem_ctrl_if (request/response + RAM)
//   mcycle          in   64  current cycle counter
//   mcycle_we_mem   out  1   load mcycle from mcycle_next_mem
//   mcycle_next_mem out  64  new mcycle value (meaningful only with we)
//   mtimecmp        in   64  current mtimecmp
//   mtimecmp_next   out  64  mtimecmp with any store applied this cycle
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] MTIMECMP_ADDR = DEFAULT_MTIMECMP_ADDR,
   parameter logic [31:0] MTIME_ADDR    = DEFAULT_MTIME_ADDR,
   parameter int          TIMEOUT       = DEFAULT_TIMEOUT
)
(
   input  logic        clk,
   input  logic        reset,
   mem_ctrl_if.slave   bus,
   input  logic [63:0] mcycle,
   output logic        mcycle_we_mem,
   output logic [63:0] mcycle_next_mem,
   input  logic [63:0] mtimecmp,
   output logic [63:0] mtimecmp_next
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0] MTIMECMP_HI_ADDR = MTIMECMP_ADDR + 32'd4;
   localparam logic [31:0] MTIME_HI_ADDR    = MTIME_ADDR + 32'd4;

   mem_ctrl_state_t state;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       addr_lo_q;

   logic [3:0]  align_be;
   logic [31:0] align_wd;
   logic        align_mis;

   logic accept;
   logic hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi, mmio_hit;
   logic misaligned, mmio_store;
   logic [31:0] mmio_rd;

   mem_store_aligner u_align (
      .unit       (bus.req_unit),
      .addr_lo    (bus.req_addr[1:0]),
      .wd         (bus.req_wd),
      .be         (align_be),
      .wd_lanes   (align_wd),
      .misaligned (align_mis)
   );

   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid & bus.req_ready;

   // Timer words are matched on the word address; the byte offset only
   // matters for the alignment check.
   assign hit_cmp_lo  = (bus.req_addr[31:2] == MTIMECMP_ADDR[31:2]);
   assign hit_cmp_hi  = (bus.req_addr[31:2] == MTIMECMP_HI_ADDR[31:2]);
   assign hit_time_lo = (bus.req_addr[31:2] == MTIME_ADDR[31:2]);
   assign hit_time_hi = (bus.req_addr[31:2] == MTIME_HI_ADDR[31:2]);
   assign mmio_hit    = hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;

   // Sub-word accesses to a timer word are treated as misaligned.
   assign misaligned = align_mis | (mmio_hit & (bus.req_unit != UNIT_WORD));
   assign mmio_store = accept & mmio_hit & ~misaligned & bus.req_we;

   // Timer stores take effect in the acceptance cycle itself so the
   // datapath registers pick them up on the same edge.
   always_comb begin
      mtimecmp_next   = mtimecmp;
      mcycle_next_mem = mcycle;
      mcycle_we_mem   = mmio_store & (hit_time_lo | hit_time_hi);
      if (mmio_store & hit_cmp_lo)  mtimecmp_next[31:0]    = bus.req_wd;
      if (mmio_store & hit_cmp_hi)  mtimecmp_next[63:32]   = bus.req_wd;
      if (mmio_store & hit_time_lo) mcycle_next_mem[31:0]  = bus.req_wd;
      if (mmio_store & hit_time_hi) mcycle_next_mem[63:32] = bus.req_wd;
   end

   // Read mux for the timer window.
   always_comb begin
      mmio_rd = 32'h0;
      if (hit_cmp_lo)       mmio_rd = mtimecmp[31:0];
      else if (hit_cmp_hi)  mmio_rd = mtimecmp[63:32];
      else if (hit_time_lo) mmio_rd = mcycle[31:0];
      else if (hit_time_hi) mmio_rd = mcycle[63:32];
   end

   // Control FSM. All RAM outputs are loaded once at acceptance and held
   // through RAM_WAIT; response data/fault hold until the next acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         addr_lo_q     <= 2'b00;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rd    <= 32'h0;
         bus.rsp_fault <= FAULT_NONE;
         bus.ram_req   <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= 32'h0;
         bus.ram_be    <= 4'b0000;
         bus.ram_wd    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               bus.rsp_valid <= 1'b0;
               if (accept) begin
                  addr_lo_q     <= bus.req_addr[1:0];
                  bus.ram_addr  <= {bus.req_addr[31:2], 2'b00};
                  bus.ram_we    <= bus.req_we;
                  bus.ram_be    <= bus.req_we ? align_be : 4'b1111;
                  bus.ram_wd    <= align_wd;
                  bus.rsp_fault <= FAULT_NONE;
                  bus.rsp_rd    <= 32'h0;
                  if (misaligned) begin
                     bus.rsp_fault <= FAULT_MISALIGNED;
                     bus.rsp_valid <= 1'b1;
                     state         <= RESP;
                  end else if (mmio_hit) begin
                     if (!bus.req_we) bus.rsp_rd <= mmio_rd;
                     bus.rsp_valid <= 1'b1;
                     state         <= RESP;
                  end else begin
                     bus.ram_req <= 1'b1;
                     wait_cnt    <= '0;
                     state       <= RAM_WAIT;
                  end
               end
            end
            RAM_WAIT: begin
               if (bus.ram_ack) begin
                  bus.rsp_rd    <= bus.ram_rd >> {addr_lo_q, 3'b000};
                  bus.ram_req   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else if (wait_cnt == CNT_MAX) begin
                  bus.rsp_fault <= FAULT_TIMEOUT;
                  bus.ram_req   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               bus.rsp_valid <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               bus.rsp_valid <= 1'b0;
               bus.ram_req   <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule
